// File: rtl/clkdiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_sequencer_if
// Description : Control and status bundle for clkdiv_sequencer. The phase
//               signal exists only when CLKDIV_PHASE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface clkdiv_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             run;
    logic             div_req;
    logic [WIDTH-1:0] div_val;
    logic             div_ack;
    logic             busy;
    logic             tick;
    logic             div_out;
    logic [WIDTH-1:0] cur_div;
`ifdef CLKDIV_PHASE_EN
    logic [WIDTH-1:0] phase;

    modport master (
        output run, div_req, div_val,
        input  div_ack, busy, tick, div_out, cur_div, phase
    );

    modport slave (
        input  run, div_req, div_val,
        output div_ack, busy, tick, div_out, cur_div, phase
    );
`else
    modport master (
        output run, div_req, div_val,
        input  div_ack, busy, tick, div_out, cur_div
    );

    modport slave (
        input  run, div_req, div_val,
        output div_ack, busy, tick, div_out, cur_div
    );
`endif
endinterface
`default_nettype wire

// File: rtl/clkdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_sequencer
// Description : Programmable clock-enable divider with glitch-free divisor
//               changes. Define CLKDIV_PHASE_EN to expose the counter as phase.
// Revision    : 1.0 - initial release
// ============================================================================
module clkdiv_sequencer #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_DIV = WIDTH'(1)
) (
    input wire                clk,
    input wire                reset,
    clkdiv_sequencer_if.slave bus
);

    localparam logic [1:0]       C_STOP = 2'd0;
    localparam logic [1:0]       C_RUN  = 2'd1;
    localparam logic [1:0]       C_PEND = 2'd2;
    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [WIDTH-1:0] pend_q,    pend_d;
    logic             tick_q,    tick_d;
    logic             dout_q,    dout_d;
    logic             ack_q,     ack_d;
    logic             busy_q,    busy_d;
    logic             w_tc;

    assign w_tc = (cnt_q == cur_div_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        pend_d    = pend_q;
        tick_d    = 1'b0;
        dout_d    = dout_q;
        ack_d     = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            C_STOP: begin
                cnt_d  = C_ZERO;
                dout_d = 1'b0;
                busy_d = 1'b0;
                // A request held across cycles must not stretch the ack pulse.
                if (bus.div_req && !ack_q) begin
                    cur_div_d = bus.div_val;
                    ack_d     = 1'b1;
                end
                if (bus.run) begin
                    state_d = C_RUN;
                end
            end

            C_RUN: begin
                if (!bus.run) begin
                    state_d = C_STOP;
                    cnt_d   = C_ZERO;
                    dout_d  = 1'b0;
                end else begin
                    if (w_tc) begin
                        cnt_d  = C_ZERO;
                        tick_d = 1'b1;
                        dout_d = ~dout_q;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                    // Latched even at terminal count so the current period completes.
                    if (bus.div_req) begin
                        pend_d  = bus.div_val;
                        busy_d  = 1'b1;
                        state_d = C_PEND;
                    end
                end
            end

            C_PEND: begin
                if (!bus.run) begin
                    state_d   = C_STOP;
                    cnt_d     = C_ZERO;
                    dout_d    = 1'b0;
                    cur_div_d = pend_q;
                    ack_d     = 1'b1;
                    busy_d    = 1'b0;
                end else if (w_tc) begin
                    state_d   = C_RUN;
                    cnt_d     = C_ZERO;
                    cur_div_d = pend_q;
                    tick_d    = 1'b1;
                    ack_d     = 1'b1;
                    dout_d    = ~dout_q;
                    busy_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end

            default: begin
                state_d = C_STOP;
                cnt_d   = C_ZERO;
                dout_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= C_STOP;
            cnt_q     <= C_ZERO;
            cur_div_q <= RESET_DIV;
            pend_q    <= C_ZERO;
            tick_q    <= 1'b0;
            dout_q    <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            dout_q    <= dout_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.tick    = tick_q;
    assign bus.div_out = dout_q;
    assign bus.div_ack = ack_q;
    assign bus.busy    = busy_q;
    assign bus.cur_div = cur_div_q;
`ifdef CLKDIV_PHASE_EN
    assign bus.phase   = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_clkdiv_sequencer
// Description : Directed vector table plus hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clkdiv_sequencer;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    clkdiv_sequencer_if #(.WIDTH(8)) bus ();

    clkdiv_sequencer #(.WIDTH(8), .RESET_DIV(8'd1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic       req;
        logic [7:0] val;
        logic       tick;
        logic       dout;
        logic       ack;
        logic       busy;
        logic [7:0] cur;
        logic [7:0] ph;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic run, input logic req, input logic [7:0] val,
                                input logic tick, input logic dout, input logic ack,
                                input logic busy, input logic [7:0] cur, input logic [7:0] ph);
        vec_t v;
        v.run = run; v.req = req; v.val = val;
        v.tick = tick; v.dout = dout; v.ack = ack; v.busy = busy; v.cur = cur; v.ph = ph;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] outs();
        return {bus.tick, bus.div_out, bus.div_ack, bus.busy, bus.cur_div};
    endfunction

    task automatic chk_phase(input string name, input logic [7:0] exp);
`ifdef CLKDIV_PHASE_EN
        chk(name, {24'd0, bus.phase}, {24'd0, exp});
`else
        if (exp === 8'hxx) $display("unreachable %s", name);
`endif
    endtask

    initial begin
        int period;
        int acks;
        logic ack_tick_ok;
        logic ack_seen;

        total = 0;
        bad   = 0;

        //            run req val   tick dout ack busy cur ph
        vecs[0]  = mk(1, 0, 8'd0, 0, 0, 0, 0, 8'd1, 8'd0);
        vecs[1]  = mk(1, 0, 8'd0, 0, 0, 0, 0, 8'd1, 8'd1);
        vecs[2]  = mk(1, 0, 8'd0, 1, 1, 0, 0, 8'd1, 8'd0);
        vecs[3]  = mk(1, 0, 8'd0, 0, 1, 0, 0, 8'd1, 8'd1);
        vecs[4]  = mk(1, 0, 8'd0, 1, 0, 0, 0, 8'd1, 8'd0);
        vecs[5]  = mk(1, 0, 8'd0, 0, 0, 0, 0, 8'd1, 8'd1);
        vecs[6]  = mk(1, 0, 8'd0, 1, 1, 0, 0, 8'd1, 8'd0);
        vecs[7]  = mk(0, 0, 8'd0, 0, 0, 0, 0, 8'd1, 8'd0);
        vecs[8]  = mk(0, 1, 8'd3, 0, 0, 1, 0, 8'd3, 8'd0);
        vecs[9]  = mk(0, 0, 8'd0, 0, 0, 0, 0, 8'd3, 8'd0);
        vecs[10] = mk(1, 0, 8'd0, 0, 0, 0, 0, 8'd3, 8'd0);
        vecs[11] = mk(1, 0, 8'd0, 0, 0, 0, 0, 8'd3, 8'd1);
        vecs[12] = mk(1, 1, 8'd0, 0, 0, 0, 1, 8'd3, 8'd2);
        vecs[13] = mk(1, 0, 8'd0, 0, 0, 0, 1, 8'd3, 8'd3);
        vecs[14] = mk(1, 0, 8'd0, 1, 1, 1, 0, 8'd0, 8'd0);
        vecs[15] = mk(1, 0, 8'd0, 1, 0, 0, 0, 8'd0, 8'd0);
        vecs[16] = mk(1, 0, 8'd0, 1, 1, 0, 0, 8'd0, 8'd0);
        vecs[17] = mk(1, 0, 8'd0, 1, 0, 0, 0, 8'd0, 8'd0);

        reset       = 1'b0;
        bus.run     = 1'b0;
        bus.div_req = 1'b0;
        bus.div_val = 8'd0;
        #2 reset = 1'b1;
        #1;
        chk("reset_outs", {20'd0, outs()}, {20'd0, 4'b0000, 8'd1});
        chk_phase("reset_phase", 8'd0);
        step();
        step();
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            bus.run     = vecs[i].run;
            bus.div_req = vecs[i].req;
            bus.div_val = vecs[i].val;
            step();
            chk($sformatf("vec%0d", i), {20'd0, outs()},
                {20'd0, vecs[i].tick, vecs[i].dout, vecs[i].ack, vecs[i].busy, vecs[i].cur});
            chk_phase($sformatf("vec%0d_phase", i), vecs[i].ph);
        end

        // Request on the terminal-count cycle with cur_div=2, new value 5.
        bus.run = 1'b0; bus.div_req = 1'b0;
        step();
        bus.div_req = 1'b1; bus.div_val = 8'd2;
        step();
        chk("stop_load2", {20'd0, outs()}, {20'd0, 4'b0010, 8'd2});
        bus.div_req = 1'b0; bus.run = 1'b1;
        step();
        step();
        step();
        bus.div_req = 1'b1; bus.div_val = 8'd5;
        step();
        chk("tc_req_tick", {20'd0, outs()}, {20'd0, 4'b1101, 8'd2});
        bus.div_req = 1'b0;
        step();
        step();
        chk("tc_req_wait", {20'd0, outs()}, {20'd0, 4'b0101, 8'd2});
        step();
        chk("tc_req_apply", {20'd0, outs()}, {20'd0, 4'b1010, 8'd5});
        period = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.tick === 1'b1) begin
                period = i;
                break;
            end
        end
        chk("period6", period, 6);

        // Second request while busy must be ignored.
        bus.div_req = 1'b1; bus.div_val = 8'd4;
        step();
        bus.div_val = 8'd7;
        step();
        chk("busy_ignore", {30'd0, bus.div_ack, bus.busy}, {30'd0, 2'b01});
        bus.div_req = 1'b0;
        acks = 0;
        ack_tick_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.div_ack === 1'b1) begin
                acks++;
                if (bus.tick !== 1'b1) ack_tick_ok = 1'b0;
            end
        end
        chk("single_ack", acks, 1);
        chk("ack_with_tick", {31'd0, ack_tick_ok}, 32'd1);
        chk("cur_div4", {24'd0, bus.cur_div}, 32'd4);

        // Stop while a request for 9 is pending.
        bus.div_req = 1'b1; bus.div_val = 8'd9;
        step();
        chk("pend9_busy", {31'd0, bus.busy}, 32'd1);
        bus.div_req = 1'b0; bus.run = 1'b0;
        step();
        chk("stop_apply", {20'd0, outs()}, {20'd0, 4'b0010, 8'd9});
        chk_phase("stop_phase", 8'd0);
        step();
        chk("stop_ack_end", {31'd0, bus.div_ack}, 32'd0);

        // Reset between edges while PEND.
        bus.run = 1'b1;
        step();
        bus.div_req = 1'b1; bus.div_val = 8'd3;
        step();
        chk("pend3_busy", {31'd0, bus.busy}, 32'd1);
        bus.div_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_reset", {20'd0, outs()}, {20'd0, 4'b0000, 8'd1});
        chk_phase("async_reset_phase", 8'd0);
        step();
        reset = 1'b0;
        ack_seen = 1'b0;
        step();
        if (bus.div_ack === 1'b1) ack_seen = 1'b1;
        chk("post_reset_e1", {31'd0, bus.tick}, 32'd0);
        step();
        if (bus.div_ack === 1'b1) ack_seen = 1'b1;
        step();
        if (bus.div_ack === 1'b1) ack_seen = 1'b1;
        chk("post_reset_tick", {31'd0, bus.tick}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.div_ack === 1'b1) ack_seen = 1'b1;
        end
        chk("no_ack_after_reset", {31'd0, ack_seen}, 32'd0);
        chk("cur_after_reset", {24'd0, bus.cur_div}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clkdiv_sequencer.md
CLKDIV_SEQUENCER -- requirements
Module: clkdiv_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the divisor and counter width in bits.
REQ-002 The block SHALL have parameter RESET_DIV, default 1, which is the divisor loaded on reset (period = RESET_DIV+1 cycles).
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL change on posedge clk only.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port run, input, 1 bit: level; 1 = divider counting, 0 = stopped.
REQ-006 Port div_req, input, 1 bit: request to load div_val.
REQ-007 Port div_val, input, WIDTH bits: requested divisor N, giving a tick period of N+1 cycles.
REQ-008 Port div_ack, output, 1 bit: registered one-cycle pulse when a request is applied.
REQ-009 Port busy, output, 1 bit: a request is latched and not yet applied.
REQ-010 Port tick, output, 1 bit: registered one-cycle clock-enable pulse at terminal count.
REQ-011 Port div_out, output, 1 bit: registered square wave that toggles at each tick.
REQ-012 Port cur_div, output, WIDTH bits: divisor currently in effect.

Function
REQ-013 The block SHALL implement three states: STOP, RUN and PEND (running with a change pending).
- counter: WIDTH bits, unsigned, no overflow possible because it is compared against cur_div.
REQ-014 In STOP, the block SHALL hold counter=0, tick=0 and div_out=0.
- div_req in STOP loads div_val into cur_div at the next edge.
- div_ack pulses in that same cycle; busy stays 0.
REQ-015 When run=1 in STOP, the block SHALL enter RUN at the next edge with counter=0.
- The first tick occurs cur_div+1 cycles after entering RUN.
REQ-016 In RUN or PEND, counter SHALL increment each cycle.
- When counter==cur_div: next edge sets counter to 0, drives tick=1 for one cycle and toggles div_out.
- Resulting period: tick = cur_div+1 cycles; div_out = 2*(cur_div+1) cycles.
REQ-017 When cur_div=0, tick SHALL be high every cycle and div_out SHALL toggle every cycle.
REQ-018 div_req in RUN SHALL latch div_val into pending, set busy=1 and move to PEND.
REQ-019 div_req while busy=1 SHALL be ignored: no ack, and pending is unchanged.
REQ-020 In PEND, at terminal count the block SHALL, at that edge:
- load cur_div from pending and set counter to 0;
- pulse tick and div_ack together, toggle div_out;
- clear busy and return to RUN.
REQ-021 div_req in RUN in the same cycle as terminal count SHALL NOT take effect at that tick.
- The request is latched and applied at the following terminal count, so the change is glitch-free and no period is shortened.
REQ-022 run=0 in RUN or PEND SHALL move the block to STOP at the next edge.
- counter=0, div_out=0, no tick.
- If a request is pending, it is applied then: cur_div updated, div_ack pulsed, busy cleared.
REQ-023 run=0 and terminal count in the same cycle SHALL give precedence to the stop: no tick is generated.
REQ-024 div_ack SHALL never be asserted for more than one consecutive cycle, and SHALL occur exactly once per accepted request.

Reset
REQ-025 reset=1 SHALL asynchronously force the following, regardless of clk:
- state=STOP, counter=0, cur_div=RESET_DIV, pending=0;
- tick=0, div_out=0, div_ack=0, busy=0.
REQ-026 Reset during PEND SHALL discard the pending request without an ack.
REQ-027 After reset deasserts, the block SHALL respond from the first clk edge.

Configuration
REQ-028 With macro CLKDIV_PHASE_EN defined, the block SHALL add output port phase, WIDTH bits.
- phase equals the internal counter value: 0 in STOP and after reset.
REQ-029 Without CLKDIV_PHASE_EN, port phase SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover:
- Reset, then run=1 with RESET_DIV=1 -> tick every 2 cycles, div_out period 4, cur_div=1.
- In RUN with cur_div=3, div_req with div_val=0 mid-period -> busy=1; at next terminal count ack+tick together; then tick every cycle.
- div_req in same cycle as tick, cur_div=2, div_val=5 -> not applied at that tick; applied at next tick 3 cycles later; subsequent period 6.
- Second div_req while busy (div_val=7 after 4) -> no extra ack; cur_div becomes 4.
- run=0 during PEND with pending=9 -> next edge STOP, div_out=0, ack pulse, cur_div=9, busy=0.
- reset asserted mid-PEND between edges -> outputs reset immediately; cur_div=RESET_DIV; no ack after release.
